// File: rtl/mini_core_lsu.sv
// mini_core_lsu -- load/store unit at the boundary of the Q103H (memory) and
// Q104H (writeback) pipeline stages of a small in-order core.
//
// Ports
//   Clock, Rst                 clock and asynchronous active-low reset
//   *Q103H inputs              instruction in the memory stage: address/ALU
//                              result, store data, PC+4, control and size
//   ReadyQ103H                 the Q103H instruction retires into Q104H this cycle
//   DMem* request outputs      single-beat request (valid/ready handshake)
//   DMemRsp* inputs            load response (valid, no backpressure)
//   RegWr*Q104H outputs        registered writeback; RegWrDataQ104H doubles as
//                              the Q104H forwarding source for execute
//   MisalignQ104H              one-cycle pulse for a dropped misaligned access
//                              (present only with the macro below)
//
// Build option
//   MINI_CORE_LSU_MISALIGN_CHK_EN  when defined, misaligned half/word accesses
//   are suppressed and flagged instead of issued with truncated byte enables.
module mini_core_lsu (
    input  logic        Clock,
    input  logic        Rst,
    input  logic [31:0] AluOutQ103H,
    input  logic [31:0] DMemWrDataQ103H,
    input  logic [31:0] PcPlus4Q103H,
    input  logic        ValidQ103H,
    input  logic        DMemRdEnQ103H,
    input  logic        DMemWrEnQ103H,
    input  logic        SignExtQ103H,
    input  logic        RegWrEnQ103H,
    input  logic [1:0]  SizeQ103H,
    input  logic [4:0]  RegDstQ103H,
    input  logic [1:0]  SelWbQ103H,
    output logic        ReadyQ103H,
    output logic        DMemReqValid,
    output logic [31:0] DMemAddr,
    output logic        DMemWrEn,
    output logic [3:0]  DMemByteEn,
    output logic [31:0] DMemWrData,
    input  logic        DMemReqReady,
    input  logic        DMemRspValid,
    input  logic [31:0] DMemRspData,
`ifdef MINI_CORE_LSU_MISALIGN_CHK_EN
    output logic        MisalignQ104H,
`endif
    output logic        RegWrEnQ104H,
    output logic [4:0]  RegDstQ104H,
    output logic [31:0] RegWrDataQ104H
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

    state_t      state;
    logic        mem_op;
    logic        is_load;
    logic        misalign;
    logic [3:0]  base_en;
    logic [31:0] wb_data;

    // Align the response lane to bit 0, keep the access width, then extend.
    function automatic logic [31:0] fmt_load(input logic [31:0] rsp,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size,
                                             input logic        sext);
        logic [31:0] sh;
        sh = rsp >> {off, 3'b000};
        case (size)
            2'd0:    fmt_load = {{24{sext & sh[7]}}, sh[7:0]};
            2'd1:    fmt_load = {{16{sext & sh[15]}}, sh[15:0]};
            default: fmt_load = sh;
        endcase
    endfunction

    assign mem_op  = ValidQ103H & (DMemRdEnQ103H | DMemWrEnQ103H);
    // An op with both enables set is handled as a store (no response expected).
    assign is_load = DMemRdEnQ103H & ~DMemWrEnQ103H;

`ifdef MINI_CORE_LSU_MISALIGN_CHK_EN
    // Size codes 2 and 3 both behave as a word access.
    assign misalign = mem_op & (((SizeQ103H == 2'd1) & AluOutQ103H[0]) |
                                (SizeQ103H[1] & (|AluOutQ103H[1:0])));
`else
    assign misalign = 1'b0;
`endif

    // Request fields come straight from the stalled Q103H instruction, so
    // they stay stable for as long as the pipeline holds it.
    assign DMemReqValid = Rst & mem_op & ~misalign & (state != WAIT_RSP);
    assign DMemAddr     = {AluOutQ103H[31:2], 2'b00};
    assign DMemWrEn     = DMemWrEnQ103H;

    always_comb begin
        case (SizeQ103H)
            2'd0:    base_en = 4'b0001;
            2'd1:    base_en = 4'b0011;
            default: base_en = 4'b1111;
        endcase
    end

    // Lanes shifted past byte 3 fall off: misaligned accesses are truncated.
    assign DMemByteEn = base_en << AluOutQ103H[1:0];

    always_comb begin
        case (SizeQ103H)
            2'd0:    DMemWrData = {4{DMemWrDataQ103H[7:0]}};
            2'd1:    DMemWrData = {2{DMemWrDataQ103H[15:0]}};
            default: DMemWrData = DMemWrDataQ103H;
        endcase
    end

    always_comb begin
        if (!mem_op || misalign)
            ReadyQ103H = 1'b1;
        else if (state == WAIT_RSP)
            ReadyQ103H = DMemRspValid;
        else
            ReadyQ103H = ~is_load & DMemReqReady;
    end

    always_comb begin
        case (SelWbQ103H)
            2'd1:    wb_data = fmt_load(DMemRspData, AluOutQ103H[1:0],
                                        SizeQ103H, SignExtQ103H);
            2'd2:    wb_data = PcPlus4Q103H;
            default: wb_data = AluOutQ103H;
        endcase
    end

    // Request handshake FSM. Responses are only looked at in WAIT_RSP, so a
    // stale response after reset or in IDLE/REQ has no effect.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, REQ: begin
                    if (DMemReqValid) begin
                        if (DMemReqReady)
                            state <= is_load ? WAIT_RSP : IDLE;
                        else
                            state <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_RSP: if (DMemRspValid) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Q103H -> Q104H: retire on ready, otherwise insert a bubble and keep
    // destination and data so forwarding still sees the last result.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            RegWrEnQ104H   <= 1'b0;
            RegDstQ104H    <= 5'd0;
            RegWrDataQ104H <= 32'd0;
        end else if (ReadyQ103H) begin
            RegWrEnQ104H   <= ValidQ103H & RegWrEnQ103H & ~misalign;
            RegDstQ104H    <= RegDstQ103H;
            RegWrDataQ104H <= wb_data;
        end else begin
            RegWrEnQ104H   <= 1'b0;
        end
    end

`ifdef MINI_CORE_LSU_MISALIGN_CHK_EN
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst)
            MisalignQ104H <= 1'b0;
        else
            MisalignQ104H <= ReadyQ103H & misalign;
    end
`endif

endmodule

// File: tb/tb_mini_core_lsu.sv
// tb_mini_core_lsu -- self-checking bench for mini_core_lsu.
// Directed scenarios with literal expectations, followed by randomized
// instruction streams against a transaction-level model of the unit.
module tb_mini_core_lsu;

    logic        Clock = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] AluOutQ103H = '0;
    logic [31:0] DMemWrDataQ103H = '0;
    logic [31:0] PcPlus4Q103H = '0;
    logic        ValidQ103H = 1'b0;
    logic        DMemRdEnQ103H = 1'b0;
    logic        DMemWrEnQ103H = 1'b0;
    logic        SignExtQ103H = 1'b0;
    logic        RegWrEnQ103H = 1'b0;
    logic [1:0]  SizeQ103H = '0;
    logic [4:0]  RegDstQ103H = '0;
    logic [1:0]  SelWbQ103H = '0;
    logic        ReadyQ103H;
    logic        DMemReqValid;
    logic [31:0] DMemAddr;
    logic        DMemWrEn;
    logic [3:0]  DMemByteEn;
    logic [31:0] DMemWrData;
    logic        DMemReqReady = 1'b0;
    logic        DMemRspValid = 1'b0;
    logic [31:0] DMemRspData = '0;
    logic        RegWrEnQ104H;
    logic [4:0]  RegDstQ104H;
    logic [31:0] RegWrDataQ104H;
`ifdef MINI_CORE_LSU_MISALIGN_CHK_EN
    logic        MisalignQ104H;
`endif

    mini_core_lsu dut (
        .Clock(Clock), .Rst(Rst),
        .AluOutQ103H(AluOutQ103H), .DMemWrDataQ103H(DMemWrDataQ103H),
        .PcPlus4Q103H(PcPlus4Q103H), .ValidQ103H(ValidQ103H),
        .DMemRdEnQ103H(DMemRdEnQ103H), .DMemWrEnQ103H(DMemWrEnQ103H),
        .SignExtQ103H(SignExtQ103H), .RegWrEnQ103H(RegWrEnQ103H),
        .SizeQ103H(SizeQ103H), .RegDstQ103H(RegDstQ103H), .SelWbQ103H(SelWbQ103H),
        .ReadyQ103H(ReadyQ103H),
        .DMemReqValid(DMemReqValid), .DMemAddr(DMemAddr), .DMemWrEn(DMemWrEn),
        .DMemByteEn(DMemByteEn), .DMemWrData(DMemWrData),
        .DMemReqReady(DMemReqReady), .DMemRspValid(DMemRspValid),
        .DMemRspData(DMemRspData),
`ifdef MINI_CORE_LSU_MISALIGN_CHK_EN
        .MisalignQ104H(MisalignQ104H),
`endif
        .RegWrEnQ104H(RegWrEnQ104H), .RegDstQ104H(RegDstQ104H),
        .RegWrDataQ104H(RegWrDataQ104H)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: a load whose request was accepted, and expected Q104H.
    logic        m_req_done = 1'b0;
    logic        m_wren = 1'b0;
    logic [4:0]  m_dst = '0;
    logic [31:0] m_data = '0;
    logic        m_mis = 1'b0;
    logic        m_ready = 1'b0;

    // DUT values observed mid-cycle by the last run_cycle.
    logic        seen_ready, seen_rv;
    logic [31:0] seen_addr, seen_wd;
    logic [3:0]  seen_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic [3:0] m_byteen(input logic [31:0] a, input logic [1:0] size);
        logic [3:0] be;
        int off;
        off = int'(a % 4);
        be = '0;
        for (int i = 0; i < 4; i++)
            be[i] = (i >= off) && (i < off + nbytes(size));
        return be;
    endfunction

    function automatic logic [31:0] m_wrdata(input logic [31:0] d, input logic [1:0] size);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = d[8*(i % nbytes(size)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rsp, input logic [31:0] a,
                                           input logic [1:0] size, input logic sext);
        logic [31:0] sh;
        longint v, span;
        sh = rsp >> (8 * (a % 4));
        span = longint'(1) << (8 * nbytes(size));
        v = longint'({32'b0, sh}) % span;
        if (sext && v >= span / 2)
            v = v - span;
        return v[31:0];
    endfunction

    function automatic logic m_misaligned(input logic [31:0] a, input logic [1:0] size);
`ifdef MINI_CORE_LSU_MISALIGN_CHK_EN
        return (a % nbytes(size)) != 0;
`else
        return (a == 32'hFFFF_FFFF) && (size == 2'd3);
`endif
    endfunction

    task automatic set_instr(input logic v, input logic rd, input logic wr, input logic sx,
                             input logic rw, input logic [1:0] sz, input logic [4:0] dst,
                             input logic [1:0] sel, input logic [31:0] alu,
                             input logic [31:0] wd, input logic [31:0] pc);
        ValidQ103H = v; DMemRdEnQ103H = rd; DMemWrEnQ103H = wr; SignExtQ103H = sx;
        RegWrEnQ103H = rw; SizeQ103H = sz; RegDstQ103H = dst; SelWbQ103H = sel;
        AluOutQ103H = alu; DMemWrDataQ103H = wd; PcPlus4Q103H = pc;
    endtask

    // One clock: compare combinational outputs mid-cycle, advance the model
    // across the edge, then compare the registered Q104H outputs.
    task automatic run_cycle();
        logic memop, mis, e_rv, e_rdy;
        logic [31:0] wb;
        @(negedge Clock);
        if (!Rst) begin
            m_req_done = 1'b0; m_wren = 1'b0; m_dst = '0; m_data = '0; m_mis = 1'b0;
        end
        memop = ValidQ103H && (DMemRdEnQ103H || DMemWrEnQ103H);
        mis   = memop && m_misaligned(AluOutQ103H, SizeQ103H);
        e_rv  = Rst && memop && !mis && !m_req_done;
        if (!memop || mis)   e_rdy = 1'b1;
        else if (m_req_done) e_rdy = DMemRspValid;
        else                 e_rdy = DMemWrEnQ103H && DMemReqReady;

        seen_ready = ReadyQ103H; seen_rv = DMemReqValid; seen_addr = DMemAddr;
        seen_be = DMemByteEn; seen_wd = DMemWrData;
        chk("ready", 32'(ReadyQ103H), 32'(e_rdy));
        chk("req_valid", 32'(DMemReqValid), 32'(e_rv));
        if (e_rv) begin
            chk("req_addr", DMemAddr, AluOutQ103H - (AluOutQ103H % 4));
            chk("req_wren", 32'(DMemWrEn), 32'(DMemWrEnQ103H));
            chk("req_byteen", 32'(DMemByteEn), 32'(m_byteen(AluOutQ103H, SizeQ103H)));
            chk("req_wrdata", DMemWrData, m_wrdata(DMemWrDataQ103H, SizeQ103H));
        end

        case (SelWbQ103H)
            2'd1:    wb = m_load(DMemRspData, AluOutQ103H, SizeQ103H, SignExtQ103H);
            2'd2:    wb = PcPlus4Q103H;
            default: wb = AluOutQ103H;
        endcase
        if (Rst) begin
            if (e_rdy) begin
                m_wren = ValidQ103H && RegWrEnQ103H && !mis;
                m_dst = RegDstQ103H; m_data = wb; m_mis = mis; m_req_done = 1'b0;
            end else begin
                m_wren = 1'b0; m_mis = 1'b0;
                if (e_rv && DMemReqReady && !DMemWrEnQ103H) m_req_done = 1'b1;
            end
        end
        m_ready = e_rdy;

        @(posedge Clock);
        #1;
        chk("q104_wren", 32'(RegWrEnQ104H), 32'(m_wren));
        chk("q104_dst", 32'(RegDstQ104H), 32'(m_dst));
        chk("q104_data", RegWrDataQ104H, m_data);
`ifdef MINI_CORE_LSU_MISALIGN_CHK_EN
        chk("q104_misalign", 32'(MisalignQ104H), 32'(m_mis));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls, cnt, kind;
        logic [1:0] sz, sel;

        // Reset with a load presented: no request may leave the unit.
        set_instr(1, 1, 0, 0, 1, 2'd2, 5'd3, 2'd1, 32'h10, 0, 0);
        DMemReqReady = 1; DMemRspValid = 1; DMemRspData = 32'hFFFF_FFFF;
        run_cycle();
        run_cycle();
        chk("rst_reqvalid", 32'(seen_rv), 32'd0);
        chk("rst_wren", 32'(RegWrEnQ104H), 32'd0);
        chk("rst_dst", 32'(RegDstQ104H), 32'd0);
        chk("rst_data", RegWrDataQ104H, 32'd0);
        set_instr(0, 0, 0, 0, 0, 2'd0, 5'd0, 2'd0, 0, 0, 0);
        DMemReqReady = 0; DMemRspValid = 0;
        Rst = 1;
        run_cycle();

        // ALU result, no memory op.
        set_instr(1, 0, 0, 0, 1, 2'd2, 5'd5, 2'd0, 32'h1234, 0, 32'h40);
        run_cycle();
        chk("add_ready", 32'(seen_ready), 32'd1);
        chk("add_wren", 32'(RegWrEnQ104H), 32'd1);
        chk("add_dst", 32'(RegDstQ104H), 32'd5);
        chk("add_data", RegWrDataQ104H, 32'h1234);

        // Byte store to 0x103, accepted immediately.
        set_instr(1, 0, 1, 0, 0, 2'd0, 5'd0, 2'd0, 32'h103, 32'hAB, 0);
        DMemReqReady = 1;
        run_cycle();
        chk("sb_ready", 32'(seen_ready), 32'd1);
        chk("sb_addr", seen_addr, 32'h100);
        chk("sb_byteen", 32'(seen_be), 32'b1000);
        chk("sb_wrdata", seen_wd, 32'hABAB_ABAB);

        // Signed half load from 0x202; response three cycles after the request.
        set_instr(1, 1, 0, 1, 1, 2'd1, 5'd7, 2'd1, 32'h202, 0, 0);
        DMemReqReady = 1; DMemRspValid = 0;
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            if (!seen_ready) stalls++;
            chk("lh_bubble", 32'(RegWrEnQ104H), 32'd0);
            DMemReqReady = 0;
        end
        chk("lh_stalls", 32'(stalls), 32'd3);
        DMemRspValid = 1; DMemRspData = 32'h8001_5A5A;
        run_cycle();
        chk("lh_ready", 32'(seen_ready), 32'd1);
        chk("lh_data", RegWrDataQ104H, 32'hFFFF_8001);
        chk("lh_wren", 32'(RegWrEnQ104H), 32'd1);

        // Request held off for two cycles, then accepted; a store follows back to back.
        set_instr(1, 1, 0, 0, 1, 2'd2, 5'd9, 2'd1, 32'h400, 0, 0);
        DMemReqReady = 0; DMemRspValid = 0;
        for (int i = 0; i < 2; i++) begin
            run_cycle();
            chk("hold_valid", 32'(seen_rv), 32'd1);
            chk("hold_addr", seen_addr, 32'h400);
            chk("hold_be", 32'(seen_be), 32'hF);
        end
        DMemReqReady = 1;
        run_cycle();
        chk("hold_accept_valid", 32'(seen_rv), 32'd1);
        DMemRspValid = 1; DMemRspData = 32'hCAFE_F00D;
        run_cycle();
        chk("hold_load_data", RegWrDataQ104H, 32'hCAFE_F00D);
        set_instr(1, 0, 1, 0, 0, 2'd1, 5'd0, 2'd0, 32'h406, 32'h1234_BEEF, 0);
        DMemRspValid = 0;
        run_cycle();
        chk("b2b_valid", 32'(seen_rv), 32'd1);
        chk("b2b_wrdata", seen_wd, 32'hBEEF_BEEF);
        chk("b2b_byteen", 32'(seen_be), 32'b1100);

        // Reset while waiting for a load response; the late response is ignored.
        set_instr(1, 1, 0, 0, 1, 2'd2, 5'd4, 2'd1, 32'h500, 0, 0);
        DMemReqReady = 1;
        run_cycle();
        DMemReqReady = 0;
        run_cycle();
        Rst = 0;
        #1;
        chk("rstw_wren", 32'(RegWrEnQ104H), 32'd0);
        chk("rstw_reqvalid", 32'(DMemReqValid), 32'd0);
        run_cycle();
        set_instr(0, 0, 0, 0, 0, 2'd0, 5'd0, 2'd0, 0, 0, 0);
        Rst = 1; DMemRspValid = 1; DMemRspData = 32'h1111_2222;
        run_cycle();
        chk("late_rsp_wren", 32'(RegWrEnQ104H), 32'd0);
        set_instr(1, 1, 0, 0, 1, 2'd2, 5'd6, 2'd1, 32'h600, 0, 0);
        DMemReqReady = 0;
        run_cycle();
        chk("late_rsp_ready", 32'(seen_ready), 32'd0);
        chk("late_rsp_reqvalid", 32'(seen_rv), 32'd1);
        DMemReqReady = 1; DMemRspValid = 0;
        run_cycle();
        DMemRspValid = 1; DMemRspData = 32'h0000_0077;
        run_cycle();
        chk("after_rst_load", RegWrDataQ104H, 32'h77);

`ifdef MINI_CORE_LSU_MISALIGN_CHK_EN
        // Misaligned word load is dropped and flagged.
        set_instr(1, 1, 0, 0, 1, 2'd2, 5'd8, 2'd1, 32'h301, 0, 0);
        DMemReqReady = 1; DMemRspValid = 0;
        run_cycle();
        chk("mis_reqvalid", 32'(seen_rv), 32'd0);
        chk("mis_ready", 32'(seen_ready), 32'd1);
        chk("mis_flag", 32'(MisalignQ104H), 32'd1);
        chk("mis_wren", 32'(RegWrEnQ104H), 32'd0);
        set_instr(0, 0, 0, 0, 0, 2'd0, 5'd0, 2'd0, 0, 0, 0);
        run_cycle();
        chk("mis_pulse_end", 32'(MisalignQ104H), 32'd0);
`else
        // Misaligned word load is issued with truncated byte enables.
        set_instr(1, 1, 0, 0, 1, 2'd2, 5'd8, 2'd1, 32'h301, 0, 0);
        DMemReqReady = 1; DMemRspValid = 0;
        run_cycle();
        chk("mis_reqvalid", 32'(seen_rv), 32'd1);
        chk("mis_byteen", 32'(seen_be), 32'b1110);
        DMemRspValid = 1; DMemRspData = 32'hAABB_CCDD;
        run_cycle();
        chk("mis_load_data", RegWrDataQ104H, 32'h00AA_BBCC);
`endif

        // Randomized instruction stream with random memory timing.
        for (int k = 0; k < 400; k++) begin
            kind = int'($urandom_range(0, 4));
            sz = 2'($urandom_range(0, 2));
            sel = 2'($urandom_range(0, 3));
            if (sel == 2'd1) sel = 2'd0;
            case (kind)
                1: set_instr(1, 0, 1, 1'($urandom), 1'($urandom), sz, 5'($urandom), sel,
                             $urandom, $urandom, $urandom);
                2, 3: set_instr(1, 1, 0, 1'($urandom), 1'($urandom), sz, 5'($urandom), 2'd1,
                                $urandom, $urandom, $urandom);
                default: set_instr(1'($urandom), 1'($urandom), 0, 0, 1'($urandom), sz,
                                   5'($urandom), sel, $urandom, $urandom, $urandom);
            endcase
            cnt = 0;
            do begin
                DMemReqReady = (cnt >= 20) ? 1'b1 : ($urandom_range(0, 2) != 0);
                DMemRspValid = m_req_done ? ((cnt >= 20) || 1'($urandom))
                                          : ($urandom_range(0, 5) == 0);
                DMemRspData  = $urandom;
                run_cycle();
                cnt++;
            end while (!m_ready && cnt < 40);
            chk("rand_retire", 32'(m_ready), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mini_core_lsu.md
MINI_CORE_LSU -- requirements
Module: mini_core_lsu

Interface
REQ-001 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Rst, input, 1 bit: asynchronous reset, active-low.
REQ-003 SHALL have inputs AluOutQ103H [31:0] (address or ALU result), DMemWrDataQ103H [31:0] (store data) and PcPlus4Q103H [31:0].
REQ-004 SHALL have inputs ValidQ103H, DMemRdEnQ103H, DMemWrEnQ103H, SignExtQ103H and RegWrEnQ103H, 1 bit each.
REQ-005 SHALL have inputs SizeQ103H [1:0] (0=byte, 1=half, 2=word), RegDstQ103H [4:0] and SelWbQ103H [1:0] (0=ALU, 1=memory, 2=PC+4).
REQ-006 SHALL have output ReadyQ103H, 1 bit: Q103H advances to Q104H this cycle.
REQ-007 SHALL have memory request outputs DMemReqValid (1), DMemAddr [31:0], DMemWrEn (1), DMemByteEn [3:0] and DMemWrData [31:0].
REQ-008 SHALL have memory inputs DMemReqReady (1), DMemRspValid (1) and DMemRspData [31:0].
REQ-009 SHALL have outputs RegWrEnQ104H (1), RegDstQ104H [5-bit] and RegWrDataQ104H [31:0]; RegWrDataQ104H is also the Q104H forwarding source for the execute stage.

Function
REQ-010 SHALL implement FSM states IDLE, REQ and WAIT_RSP.
REQ-011 SHALL treat a Q103H entry as a memory op when ValidQ103H=1 and DMemRdEnQ103H or DMemWrEnQ103H is 1.
REQ-012 SHALL, for a non-memory op, assert ReadyQ103H=1 combinationally in the same cycle, with zero stall.
REQ-013 SHALL, for a memory op in IDLE or REQ, drive DMemReqValid=1 combinationally and hold DMemAddr, DMemWrEn, DMemByteEn and DMemWrData stable until DMemReqReady=1.
REQ-014 SHALL go IDLE->REQ when DMemReqValid=1 and DMemReqReady=0, and stay in REQ until DMemReqReady=1.
REQ-015 SHALL, for a store, assert ReadyQ103H=1 in the cycle DMemReqReady=1 and return to or remain in IDLE; a store expects no response.
REQ-016 SHALL, for a load, go to WAIT_RSP on request accept with ReadyQ103H=0.
REQ-017 SHALL, in WAIT_RSP, drive DMemReqValid=0; on DMemRspValid=1 it SHALL assert ReadyQ103H=1 and return to IDLE.
REQ-018 SHALL ignore DMemRspValid in IDLE and REQ.
REQ-019 SHALL drive DMemAddr = {AluOutQ103H[31:2], 2'b00}.
REQ-020 SHALL set DMemByteEn to base enables (byte 0001, half 0011, word 1111) shifted left by AluOutQ103H[1:0], truncated to 4 bits.
REQ-021 SHALL set DMemWrData to the store data replicated into every lane (byte x4, half x2, word as-is).
REQ-022 SHALL, for load data, shift DMemRspData right by 8*AluOutQ103H[1:0], take the SizeQ103H width, then sign-extend if SignExtQ103H=1, else zero-extend.
REQ-023 SHALL register Q104H outputs when ReadyQ103H=1: RegWrEnQ104H <= ValidQ103H & RegWrEnQ103H and RegDstQ104H <= RegDstQ103H.
REQ-024 SHALL register RegWrDataQ104H <= ALU, formatted load data or PcPlus4Q103H, chosen by SelWbQ103H; SelWbQ103H=3 SHALL select ALU.
REQ-025 SHALL, when ReadyQ103H=0, clock RegWrEnQ104H <= 0 (a bubble) and hold RegDstQ104H and RegWrDataQ104H.
REQ-026 SHALL allow back-to-back memory ops: a new request may issue in the cycle after a completion, with no idle gap required.

Reset
REQ-027 SHALL, while Rst=0, force the FSM to IDLE, RegWrEnQ104H=0, RegDstQ104H=0, RegWrDataQ104H=0 and DMemReqValid=0, regardless of Clock.
REQ-028 SHALL abandon any in-flight load on reset; a DMemRspValid arriving after reset release SHALL be ignored per REQ-018.

Configuration
REQ-029 SHALL provide macro MINI_CORE_LSU_MISALIGN_CHK_EN.
REQ-030 SHALL, when the macro is defined, treat as misaligned a half access with AluOutQ103H[0]=1 and a word access with AluOutQ103H[1:0]!=0.
REQ-031 SHALL, for a misaligned access with the macro defined: issue no memory request, assert ReadyQ103H=1 immediately, register RegWrEnQ104H=0 and pulse output MisalignQ104H=1 for one cycle.
REQ-032 SHALL reset MisalignQ104H to 0.
REQ-033 SHALL, when the macro is undefined, not have port MisalignQ104H and issue misaligned accesses with the truncated byte enables of REQ-020.

Verification
REQ-034 SHALL cover: ADD result 0x1234, RegDst=5, no memory op -> RegWrDataQ104H=0x1234, RegWrEnQ104H=1 on the next edge, ReadyQ103H=1 throughout.
REQ-035 SHALL cover: byte store data 0xAB to address 0x103, DMemReqReady=1 -> DMemByteEn=1000, DMemWrData=0xABABABAB, DMemAddr=0x100, single cycle.
REQ-036 SHALL cover: signed half load from 0x202, response 0x8001xxxx after 3 cycles -> ReadyQ103H=0 for 3 cycles with bubbles, then RegWrDataQ104H=0xFFFF8001.
REQ-037 SHALL cover: DMemReqReady held 0 for 2 cycles -> DMemReqValid=1 and request fields stable for 2 cycles, FSM in REQ, then accept.
REQ-038 SHALL cover: Rst asserted in WAIT_RSP, then a late DMemRspValid -> FSM in IDLE, RegWrEnQ104H=0, response ignored.
REQ-039 SHALL cover, macro defined: word load from 0x301 -> DMemReqValid=0, MisalignQ104H=1 for one cycle, RegWrEnQ104H=0.
